// File: rtl/apbt1_pkg.sv
// Shared types and constants for the APB-T1 LINT-to-eFPGA bridge.
package apbt1_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [31:0] ERR_RDATA          = 32'hBADACCE5;
  localparam int          DEFAULT_ADDR_WIDTH = 20;

  // Packed request is {wen, addr, be, wdata}; wen=1 means read.
  function automatic int req_w(input int addr_width);
    return 1 + addr_width + 4 + 32;
  endfunction

  typedef struct packed {
    logic                          wen;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [3:0]                    be;
    logic [31:0]                   wdata;
  } lint_req_t;

endpackage

// File: rtl/apbt1_timeout_cnt.sv
// Loadable saturating up-counter; hit is high while the count sits at MAX_COUNT.
module apbt1_timeout_cnt
  import apbt1_pkg::*;
#(
  parameter int MAX_COUNT = 255,
  localparam int CNT_W = $clog2(MAX_COUNT + 1)
) (
  input  logic             lint_clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic             hit
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] count_reg;

  assign hit = (count_reg == MAX_C);

  always_ff @(posedge lint_clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (inc && !hit) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/apbt1_lint_bridge.sv
// One-deep LINT-to-eFPGA request bridge: capture, replay to fabric, return rdata.
// Optional fabric-response timeout is enabled with `define APBT1_TIMEOUT_EN.
module apbt1_lint_bridge
  import apbt1_pkg::*;
#(
  parameter int ADDR_WIDTH     = 20,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int REQ_W = req_w(ADDR_WIDTH)
) (
  input  logic             lint_clk,
  input  logic             rst_n,
  input  logic             lint_req,
  input  logic [REQ_W-1:0] lint_req_data,
  output logic             lint_gnt,
  output logic             lint_valid,
  output logic [31:0]      lint_rdata,
  output logic             lint_fmo,
  output logic             efpga_req,
  output logic [REQ_W-1:0] efpga_req_data,
  input  logic             efpga_gnt,
  input  logic             efpga_valid,
  input  logic [31:0]      efpga_rdata
);

  state_t           state_reg, state_next;
  logic             efpga_req_reg;
  logic [REQ_W-1:0] efpga_req_data_reg;
  logic             lint_valid_reg;
  logic [31:0]      lint_rdata_reg;
  logic             lint_fmo_reg;

  logic capture;
  logic take_rdata;
  logic timeout_fire;
  logic timeout_hit;

`ifdef APBT1_TIMEOUT_EN
  // Held clear through IDLE so the count starts at zero on entry to REQ.
  apbt1_timeout_cnt #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .lint_clk (lint_clk),
    .rst_n    (rst_n),
    .load     (state_reg == IDLE),
    .load_val ('0),
    .inc      ((state_reg == REQ) || (state_reg == WAIT)),
    .hit      (timeout_hit)
  );
`else
  localparam logic [31:0] TIMEOUT_C = TIMEOUT_CYCLES;
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_C;
  assign timeout_hit    = 1'b0;
`endif

  // Gated by reset so a request held across reset is not granted early.
  assign lint_gnt = rst_n && (state_reg == IDLE) && lint_req;

  always_comb begin
    state_next   = state_reg;
    capture      = 1'b0;
    take_rdata   = 1'b0;
    timeout_fire = 1'b0;
    case (state_reg)
      IDLE: begin
        if (lint_req) begin
          state_next = REQ;
          capture    = 1'b1;
        end
      end
      REQ: begin
        if (efpga_gnt) begin
          state_next = WAIT;
        end else if (timeout_hit) begin
          state_next   = RESP;
          timeout_fire = 1'b1;
        end
      end
      WAIT: begin
        // A real response in the same cycle as the timeout wins.
        if (efpga_valid) begin
          state_next = RESP;
          take_rdata = 1'b1;
        end else if (timeout_hit) begin
          state_next   = RESP;
          timeout_fire = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge lint_clk) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      efpga_req_reg      <= 1'b0;
      efpga_req_data_reg <= '0;
      lint_valid_reg     <= 1'b0;
      lint_rdata_reg     <= '0;
      lint_fmo_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      efpga_req_reg  <= (state_next == REQ);
      lint_valid_reg <= (state_next == RESP);
      lint_fmo_reg   <= timeout_fire;
      if (capture) begin
        efpga_req_data_reg <= lint_req_data;
      end
      if (take_rdata) begin
        lint_rdata_reg <= efpga_rdata;
      end else if (timeout_fire) begin
        lint_rdata_reg <= ERR_RDATA;
      end
    end
  end

  assign efpga_req      = efpga_req_reg;
  assign efpga_req_data = efpga_req_data_reg;
  assign lint_valid     = lint_valid_reg;
  assign lint_rdata     = lint_rdata_reg;
  assign lint_fmo       = lint_fmo_reg;

endmodule

// File: tb/tb_apbt1_lint_bridge.sv
// Self-checking bench for apbt1_lint_bridge: vector table, corner sequences, random traffic.
module tb_apbt1_lint_bridge;
  import apbt1_pkg::*;

  localparam int AW = 20;
  localparam int RW = req_w(AW);
  localparam int TO = 8;

  logic          lint_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lint_req = 1'b0;
  logic [RW-1:0] lint_req_data = '0;
  logic          lint_gnt;
  logic          lint_valid;
  logic [31:0]   lint_rdata;
  logic          lint_fmo;
  logic          efpga_req;
  logic [RW-1:0] efpga_req_data;
  logic          efpga_gnt = 1'b0;
  logic          efpga_valid = 1'b0;
  logic [31:0]   efpga_rdata = '0;

  apbt1_lint_bridge #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .lint_clk       (lint_clk),
    .rst_n          (rst_n),
    .lint_req       (lint_req),
    .lint_req_data  (lint_req_data),
    .lint_gnt       (lint_gnt),
    .lint_valid     (lint_valid),
    .lint_rdata     (lint_rdata),
    .lint_fmo       (lint_fmo),
    .efpga_req      (efpga_req),
    .efpga_req_data (efpga_req_data),
    .efpga_gnt      (efpga_gnt),
    .efpga_valid    (efpga_valid),
    .efpga_rdata    (efpga_rdata)
  );

  always #5 lint_clk = ~lint_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge lint_clk);
    #1;
  endtask

  // One transaction, starting at cycle 0 with lint_req raised. The fabric side
  // grants gd cycles after efpga_req appears and answers vd cycles after the
  // grant. lat is the cycle (relative to acceptance) in which lint_valid is seen.
  task automatic drive_txn(input lint_req_t rq, input int gd, input int vd,
                           input logic [31:0] rd, input bit spurious,
                           input bit hold, input lint_req_t nxt,
                           output int lat, output logic [31:0] rdata,
                           output logic fmo);
    int fs, gk, vk;
    fs = 0; gk = 0; vk = 0; lat = -1; rdata = '0; fmo = 1'b0;
    lint_req      = 1'b1;
    lint_req_data = rq;
    @(negedge lint_clk);
    check("gnt_accept", lint_gnt, 1);
    check("valid_single_pulse", lint_valid, 0);
    next_cycle();
    lint_req = 1'b0;
    for (int c = 1; c <= 64 && lat < 0; c++) begin
      efpga_gnt   = 1'b0;
      efpga_valid = 1'b0;
      if (hold && c >= 2) begin
        lint_req      = 1'b1;
        lint_req_data = nxt;
      end
      if (fs == 0 && efpga_req) begin
        check("req_data_stable", efpga_req_data, rq);
        if (gk == gd) begin
          efpga_gnt = 1'b1;
          fs = 1;
        end else begin
          gk++;
          efpga_valid = spurious;
          efpga_rdata = $urandom;
        end
      end else if (fs == 1) begin
        check("req_drop_in_wait", efpga_req, 0);
        if (vk == vd) begin
          efpga_valid = 1'b1;
          efpga_rdata = rd;
          fs = 2;
        end else begin
          vk++;
          efpga_gnt = spurious;
        end
      end
      @(negedge lint_clk);
      if (hold && c >= 2) check("busy_gnt_held", lint_gnt, 0);
      if (lint_valid) begin
        lat   = c;
        rdata = lint_rdata;
        fmo   = lint_fmo;
      end
      next_cycle();
    end
    efpga_gnt   = 1'b0;
    efpga_valid = 1'b0;
    if (lat < 0) check("resp_seen", 0, 1);
  endtask

  typedef struct {
    lint_req_t   rq;
    int          gd;
    int          vd;
    logic [31:0] rd;
    int          exp_lat;
  } vec_t;

  vec_t      vecs[5];
  lint_req_t rq_a, rq_b, none;
  int        lat;
  logic [31:0] rdata;
  logic      fmo;

  initial begin
    none = '0;
    vecs[0] = '{'{1'b1, 20'h00010, 4'hF, 32'h0},        0, 0, 32'hCAFE0001, 3};
    vecs[1] = '{'{1'b0, 20'h00100, 4'h3, 32'h12345678}, 4, 2, 32'h5A5A0000, 9};
    vecs[2] = '{'{1'b1, 20'hFFFFF, 4'h1, 32'h0},        1, 0, 32'h00000001, 4};
    vecs[3] = '{'{1'b0, 20'h0ABCD, 4'hC, 32'hFFFFFFFF}, 0, 3, 32'h76543210, 6};
    vecs[4] = '{'{1'b1, 20'h00000, 4'h8, 32'h0},        2, 1, 32'hFFFFFFFF, 6};

    // Reset held with a pending request: no grant, all outputs cleared.
    lint_req      = 1'b1;
    lint_req_data = vecs[0].rq;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge lint_clk);
      check("rst_ctrl_outputs", {lint_gnt, lint_valid, lint_fmo, efpga_req}, 0);
      check("rst_rdata", lint_rdata, 0);
      check("rst_req_data", efpga_req_data, 0);
      next_cycle();
    end
    rst_n = 1'b1;

    // Vector table; the first entry is granted in the first cycle out of reset.
    for (int i = 0; i < 5; i++) begin
      drive_txn(vecs[i].rq, vecs[i].gd, vecs[i].vd, vecs[i].rd, 1'b0, 1'b0, none,
                lat, rdata, fmo);
      $display("[TB] vec %0d wen=%0d addr=%05h lat=%0d rdata=%08h fmo=%0d",
               i, vecs[i].rq.wen, vecs[i].rq.addr, lat, rdata, fmo);
      check("vec_latency", lat, vecs[i].exp_lat);
      check("vec_rdata", rdata, vecs[i].rd);
      check("vec_fmo", fmo, 0);
    end

    // Busy hold-off: second request waits, then completes with its own data.
    rq_a = '{1'b1, 20'h00020, 4'hF, 32'h0};
    rq_b = '{1'b0, 20'h00030, 4'h6, 32'hA5A5A5A5};
    drive_txn(rq_a, 0, 3, 32'h11112222, 1'b0, 1'b1, rq_b, lat, rdata, fmo);
    $display("[TB] busy first lat=%0d rdata=%08h", lat, rdata);
    check("busy_a_latency", lat, 6);
    check("busy_a_rdata", rdata, 32'h11112222);
    drive_txn(rq_b, 1, 1, 32'h33334444, 1'b0, 1'b0, none, lat, rdata, fmo);
    $display("[TB] busy second lat=%0d rdata=%08h", lat, rdata);
    check("busy_b_latency", lat, 5);
    check("busy_b_rdata", rdata, 32'h33334444);

    // Spurious fabric handshakes in IDLE, then inside REQ/WAIT.
    efpga_valid = 1'b1;
    efpga_gnt   = 1'b1;
    efpga_rdata = 32'hDEAD0000;
    next_cycle();
    efpga_valid = 1'b0;
    efpga_gnt   = 1'b0;
    @(negedge lint_clk);
    $display("[TB] spurious idle valid=%0d req=%0d", lint_valid, efpga_req);
    check("spur_idle_valid", lint_valid, 0);
    check("spur_idle_req", efpga_req, 0);
    check("spur_idle_rdata", lint_rdata, 32'h33334444);
    next_cycle();
    drive_txn(rq_a, 2, 2, 32'h55556666, 1'b1, 1'b0, none, lat, rdata, fmo);
    $display("[TB] spurious busy lat=%0d rdata=%08h", lat, rdata);
    check("spur_latency", lat, 7);
    check("spur_rdata", rdata, 32'h55556666);

    // Reset in WAIT: transaction abandoned, late fabric answer ignored.
    lint_req      = 1'b1;
    lint_req_data = rq_b;
    next_cycle();
    lint_req  = 1'b0;
    efpga_gnt = 1'b1;
    next_cycle();
    efpga_gnt = 1'b0;
    rst_n     = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge lint_clk);
    check("midrst_req", efpga_req, 0);
    check("midrst_valid", lint_valid, 0);
    next_cycle();
    efpga_valid = 1'b1;
    efpga_rdata = 32'hDEADBEEF;
    next_cycle();
    efpga_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge lint_clk);
      check("midrst_no_resp", lint_valid, 0);
      check("midrst_rdata", lint_rdata, 0);
      next_cycle();
    end
    $display("[TB] reset in WAIT: no response issued");

`ifdef APBT1_TIMEOUT_EN
    // Fabric never grants: timeout response two cycles past the limit count.
    drive_txn(rq_a, 1000, 0, 32'h0, 1'b0, 1'b0, none, lat, rdata, fmo);
    $display("[TB] timeout lat=%0d rdata=%08h fmo=%0d", lat, rdata, fmo);
    check("to_latency", lat, TO + 2);
    check("to_rdata", rdata, ERR_RDATA);
    check("to_fmo", fmo, 1);
    efpga_valid = 1'b1;
    efpga_rdata = 32'h0BADF00D;
    next_cycle();
    efpga_valid = 1'b0;
    @(negedge lint_clk);
    check("to_late_valid", lint_valid, 0);
    check("to_req_dropped", efpga_req, 0);
    next_cycle();
`endif

    // Random traffic against the spec's latency and data rules.
    for (int i = 0; i < 24; i++) begin
      lint_req_t   rq;
      int          gd, vd, gap;
      logic [31:0] rd;
      bit          sp;
      rq  = '{1'($urandom), 20'($urandom), 4'($urandom), $urandom};
      gd  = $urandom_range(0, 3);
      vd  = $urandom_range(0, 2);
      rd  = $urandom;
      sp  = 1'($urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) next_cycle();
      drive_txn(rq, gd, vd, rd, sp, 1'b0, none, lat, rdata, fmo);
      $display("[TB] rand %0d gd=%0d vd=%0d lat=%0d rdata=%08h", i, gd, vd, lat, rdata);
      check("rand_latency", lat, 3 + gd + vd);
      check("rand_rdata", rdata, rd);
      check("rand_fmo", fmo, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
